data_mem_dump_arbiter: RTL and testbench
========================================

Name: data_mem_dump_arbiter

Overview:
Shares the MEM-stage data memory between the pipeline load/store path and a debug memory-dump sequencer. On request, and only while the pipeline is halted, the sequencer reads every word of data memory and streams it byte by byte to the debug UART transmitter over a valid/ready handshake. In all other states the block is a transparent pass-through from the pipeline controls to the memory. It sits between memory_access and full_memory, alongside the debug unit.

Parameters:
NB_DATA, 32, data word width
N_DATA_MEM_ADDR, 64, data memory size in bytes (multiple of 4)
NB_ADDR_MEM, $clog2(N_DATA_MEM_ADDR), memory byte-address width
NB_BYTE, 8, TX byte width
WORD_ADDRESSING, 2'b11, addressing code for full-word access

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_pipe_r_en  in  1  pipeline read enable
i_pipe_w_en  in  1  pipeline write enable
i_pipe_addr  in  NB_ADDR_MEM  pipeline byte address
i_pipe_w_data  in  NB_DATA  pipeline write data
i_pipe_addressing  in  2  pipeline access size
i_pipe_signing  in  1  pipeline sign-extend select
o_pipe_r_data  out  NB_DATA  read data returned to pipeline
i_pipe_halted  in  1  pipeline frozen; dump is allowed to use memory
i_dump_start  in  1  single-cycle dump request
o_dump_busy  out  1  high from accepted start until DONE inclusive
o_dump_done  out  1  one-cycle pulse at dump end
o_mem_r_en / o_mem_w_en  out  1 each  to memory
o_mem_addr  out  NB_ADDR_MEM  to memory
o_mem_w_data  out  NB_DATA  to memory
o_mem_addressing  out  2  to memory
o_mem_signing  out  1  to memory
i_mem_r_data  in  NB_DATA  memory read data, combinational and valid in the same cycle
o_tx_data  out  NB_BYTE  byte to UART TX
o_tx_valid  out  1  byte valid
i_tx_ready  in  1  TX accepts the byte when valid and ready are both high

Behaviour:
- The clock and reset are as stated above: one clock i_clk; i_reset is asynchronous and active-high. Reset forces IDLE and clears the word/byte counters, the capture register, o_tx_data, o_tx_valid, o_dump_busy and o_dump_done to 0 immediately, with no clock edge needed. A reset in the middle of a dump aborts it; no done pulse is produced.
- Memory mux: in every state except READ, the o_mem_* outputs equal the i_pipe_* inputs combinationally.
- Memory mux in READ: o_mem_r_en=1, o_mem_w_en=0, o_mem_addr={word_cnt,2'b00}, o_mem_addressing=WORD_ADDRESSING, o_mem_signing=0. Pipeline writes are blocked.
- o_pipe_r_data = i_mem_r_data at all times.
- FSM states: IDLE, WAIT_HALT, READ, SEND, NEXT, DONE.
- IDLE: when i_dump_start=1, set word_cnt=0 and go to WAIT_HALT. A start pulse outside IDLE is ignored.
- WAIT_HALT: go to READ when i_pipe_halted=1.
- READ: if i_pipe_halted=1, capture i_mem_r_data into word_reg, set byte_idx=0 and go to SEND. If i_pipe_halted=0, perform no read and return to WAIT_HALT.
- SEND: o_tx_valid=1 and o_tx_data=word_reg byte[byte_idx], LSB byte first. Both stay stable until accepted.
- SEND handshake: on valid&&ready, if byte_idx=3 go to NEXT, otherwise increment byte_idx.
- NEXT: if word_cnt = N_DATA_MEM_ADDR/4-1, go to DONE. Otherwise increment word_cnt and go to READ if i_pipe_halted=1, else to WAIT_HALT.
- DONE: o_dump_done=1 for exactly one cycle, then IDLE.
- If i_pipe_halted drops during SEND, the current word finishes transmitting; the next read waits for the halt to return.
- Latency, with halt held high and ready held high: start accepted at edge k; first o_tx_valid after edge k+2. Each word then takes 4 SEND cycles + 1 NEXT cycle + 1 READ cycle. The whole dump emits exactly N_DATA_MEM_ADDR bytes.
- o_tx_valid is never high outside SEND.

Test Plan:
- Pass-through: IDLE, pipeline writes 0xDEADBEEF to address 8, then reads address 8 -> o_pipe_r_data=0xDEADBEEF; o_tx_valid stays 0.
- Full dump: memory word n preloaded with 0x03020100+0x04040404*n, halted=1, ready=1, pulse start -> 64 bytes 0x00..0x3F in order; o_dump_done pulses once; o_dump_busy falls after DONE.
- Backpressure: ready toggles 1-of-3 cycles -> o_tx_data holds each byte until accepted; byte sequence identical to the full-dump case.
- Halt gating: start with halted=0 -> stays in WAIT_HALT, o_mem_* follow the pipeline; raise halt -> dump proceeds. Drop halt during word 5 SEND -> word 5 completes, no read of word 6 until halt returns.
- Ignored start: a second i_dump_start during a dump -> no restart; total byte count is still 64.
- Async reset: assert i_reset during SEND of word 3, between clock edges -> o_tx_valid=0 and o_dump_busy=0 immediately. A new start afterwards dumps from byte 0.

Source files
------------

// File: rtl/data_mem_dump_arbiter.sv
// Data memory arbiter: pipeline pass-through, or debug dump of
// every word, streamed LSB byte first to the UART TX handshake.
module data_mem_dump_arbiter #(
  parameter int         NB_DATA         = 32,
  parameter int         N_DATA_MEM_ADDR = 64,
  parameter int         NB_ADDR_MEM     = $clog2(N_DATA_MEM_ADDR),
  parameter int         NB_BYTE         = 8,
  parameter logic [1:0] WORD_ADDRESSING = 2'b11
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_pipe_r_en,
  input  logic                   i_pipe_w_en,
  input  logic [NB_ADDR_MEM-1:0] i_pipe_addr,
  input  logic [NB_DATA-1:0]     i_pipe_w_data,
  input  logic [1:0]             i_pipe_addressing,
  input  logic                   i_pipe_signing,
  output logic [NB_DATA-1:0]     o_pipe_r_data,
  input  logic                   i_pipe_halted,
  input  logic                   i_dump_start,
  output logic                   o_dump_busy,
  output logic                   o_dump_done,
  output logic                   o_mem_r_en,
  output logic                   o_mem_w_en,
  output logic [NB_ADDR_MEM-1:0] o_mem_addr,
  output logic [NB_DATA-1:0]     o_mem_w_data,
  output logic [1:0]             o_mem_addressing,
  output logic                   o_mem_signing,
  input  logic [NB_DATA-1:0]     i_mem_r_data,
  output logic [NB_BYTE-1:0]     o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready
);

  localparam int NB_WCNT = NB_ADDR_MEM - 2;
  localparam logic [NB_WCNT-1:0] LAST_WORD =
    NB_WCNT'(N_DATA_MEM_ADDR / 4 - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HALT,
    READ,
    SEND,
    NEXT,
    DONE
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [NB_WCNT-1:0]   word_cnt;
  logic [1:0]           byte_idx;
  logic [NB_DATA-1:0]   word_reg;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:
        if (i_dump_start)
          state_next = WAIT_HALT;
      WAIT_HALT:
        if (i_pipe_halted)
          state_next = READ;
      READ:
        state_next = i_pipe_halted ? SEND : WAIT_HALT;
      SEND:
        if (i_tx_ready && byte_idx == 2'd3)
          state_next = NEXT;
      NEXT:
        if (word_cnt == LAST_WORD)
          state_next = DONE;
        else
          state_next = i_pipe_halted ? READ : WAIT_HALT;
      DONE:
        state_next = IDLE;
      default:
        state_next = IDLE;
    endcase
  end

  // Counters and capture register follow the FSM transitions above.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      word_cnt <= '0;
      byte_idx <= '0;
      word_reg <= '0;
    end else begin
      unique case (state)
        IDLE:
          if (i_dump_start)
            word_cnt <= '0;
        READ:
          if (i_pipe_halted) begin
            word_reg <= i_mem_r_data;
            byte_idx <= '0;
          end
        SEND:
          if (i_tx_ready && byte_idx != 2'd3)
            byte_idx <= byte_idx + 2'd1;
        NEXT:
          if (word_cnt != LAST_WORD)
            word_cnt <= word_cnt + NB_WCNT'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    o_mem_r_en       = i_pipe_r_en;
    o_mem_w_en       = i_pipe_w_en;
    o_mem_addr       = i_pipe_addr;
    o_mem_w_data     = i_pipe_w_data;
    o_mem_addressing = i_pipe_addressing;
    o_mem_signing    = i_pipe_signing;
    if (state == READ) begin
      o_mem_r_en       = 1'b1;
      o_mem_w_en       = 1'b0;
      o_mem_addr       = {word_cnt, 2'b00};
      o_mem_addressing = WORD_ADDRESSING;
      o_mem_signing    = 1'b0;
    end
  end

  assign o_pipe_r_data = i_mem_r_data;
  assign o_tx_valid    = (state == SEND);
  assign o_tx_data     = word_reg[byte_idx*NB_BYTE +: NB_BYTE];
  assign o_dump_busy   = (state != IDLE);
  assign o_dump_done   = (state == DONE);

endmodule

// File: tb/tb_data_mem_dump_arbiter.sv
// Bench for data_mem_dump_arbiter: memory model, byte-stream
// reference built from memory contents, directed + random steps.
module tb_data_mem_dump_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_pipe_r_en;
  logic        i_pipe_w_en;
  logic [5:0]  i_pipe_addr;
  logic [31:0] i_pipe_w_data;
  logic [1:0]  i_pipe_addressing;
  logic        i_pipe_signing;
  logic [31:0] o_pipe_r_data;
  logic        i_pipe_halted;
  logic        i_dump_start;
  logic        o_dump_busy;
  logic        o_dump_done;
  logic        o_mem_r_en;
  logic        o_mem_w_en;
  logic [5:0]  o_mem_addr;
  logic [31:0] o_mem_w_data;
  logic [1:0]  o_mem_addressing;
  logic        o_mem_signing;
  logic [31:0] i_mem_r_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;

  data_mem_dump_arbiter dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_pipe_r_en       (i_pipe_r_en),
    .i_pipe_w_en       (i_pipe_w_en),
    .i_pipe_addr       (i_pipe_addr),
    .i_pipe_w_data     (i_pipe_w_data),
    .i_pipe_addressing (i_pipe_addressing),
    .i_pipe_signing    (i_pipe_signing),
    .o_pipe_r_data     (o_pipe_r_data),
    .i_pipe_halted     (i_pipe_halted),
    .i_dump_start      (i_dump_start),
    .o_dump_busy       (o_dump_busy),
    .o_dump_done       (o_dump_done),
    .o_mem_r_en        (o_mem_r_en),
    .o_mem_w_en        (o_mem_w_en),
    .o_mem_addr        (o_mem_addr),
    .o_mem_w_data      (o_mem_w_data),
    .o_mem_addressing  (o_mem_addressing),
    .o_mem_signing     (o_mem_signing),
    .i_mem_r_data      (i_mem_r_data),
    .o_tx_data         (o_tx_data),
    .o_tx_valid        (o_tx_valid),
    .i_tx_ready        (i_tx_ready)
  );

  initial forever #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [16];
  logic [31:0] mem_init [16];
  logic        load = 1'b0;

  always @(posedge i_clk) begin
    if (load) mem <= mem_init;
    else if (o_mem_w_en) mem[o_mem_addr[5:2]] <= o_mem_w_data;
  end
  assign i_mem_r_data = mem[o_mem_addr[5:2]];

  int ready_mode = 0;
  int rcyc = 0;
  initial begin
    i_tx_ready = 1'b1;
    forever begin
      @(negedge i_clk);
      rcyc++;
      case (ready_mode)
        1: i_tx_ready = (rcyc % 3 == 0);
        2: i_tx_ready = 1'($urandom_range(0, 1));
        default: i_tx_ready = 1'b1;
      endcase
    end
  end

  logic [7:0] rx [$];
  int         done_cnt = 0;
  int         valid_cnt = 0;
  int         viol = 0;
  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic [7:0] prev_d = 8'h0;

  always @(posedge i_clk) begin
    if (i_reset) begin
      prev_v = 1'b0;
    end else begin
      if (o_tx_valid) valid_cnt++;
      if (o_tx_valid && i_tx_ready) rx.push_back(o_tx_data);
      if (o_dump_done) done_cnt++;
      if (o_dump_done && !o_dump_busy) viol++;
      if (prev_v && !prev_r)
        if (!(o_tx_valid && o_tx_data == prev_d)) viol++;
      prev_v = o_tx_valid;
      prev_r = i_tx_ready;
      prev_d = o_tx_data;
    end
  end

  logic [7:0] exp_q [$];
  int base;
  int dbase;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input bit rnd);
    exp_q.delete();
    for (int w = 0; w < 16; w++) begin
      mem_init[w] = rnd ? $urandom : 32'h03020100 + 32'h04040404 * w;
      for (int b = 0; b < 4; b++)
        exp_q.push_back(8'(mem_init[w] >> (8 * b)));
    end
    @(negedge i_clk) load = 1'b1;
    @(negedge i_clk) load = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge i_clk) i_dump_start = 1'b1;
    @(negedge i_clk) i_dump_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 3000; n++) begin
      @(posedge i_clk) #1;
      if (!o_dump_busy) break;
    end
    chk(tag, 32'(o_dump_busy), 32'd0);
  endtask

  task automatic wait_rx(input int n, input string tag);
    for (int c = 0; c < 3000; c++) begin
      if (rx.size() - base >= n) break;
      @(posedge i_clk) #1;
    end
    chk(tag, 32'(rx.size() - base >= n), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    int mism = 0;
    chk({tag, "_cnt"}, 32'(rx.size() - base), 32'd64);
    for (int i = 0; i < 64 && base + i < rx.size(); i++)
      if (rx[base + i] !== exp_q[i]) mism++;
    chk({tag, "_bytes"}, 32'(mism), 32'd0);
    chk({tag, "_done"}, 32'(done_cnt - dbase), 32'd1);
  endtask

  initial begin
    i_reset = 1'b1;
    i_pipe_r_en = 0;
    i_pipe_w_en = 0;
    i_pipe_addr = '0;
    i_pipe_w_data = '0;
    i_pipe_addressing = 2'b11;
    i_pipe_signing = 0;
    i_pipe_halted = 0;
    i_dump_start = 0;
    #1;
    chk("rst_valid", 32'(o_tx_valid), 32'd0);
    chk("rst_busy", 32'(o_dump_busy), 32'd0);
    chk("rst_done", 32'(o_dump_done), 32'd0);
    chk("rst_data", 32'(o_tx_data), 32'd0);
    @(negedge i_clk) i_reset = 1'b0;

    // pass-through write then read
    @(negedge i_clk);
    i_pipe_w_en = 1;
    i_pipe_addr = 6'd8;
    i_pipe_w_data = 32'hDEADBEEF;
    #1;
    chk("pt_wen", 32'(o_mem_w_en), 32'd1);
    chk("pt_addr", 32'(o_mem_addr), 32'd8);
    chk("pt_wdata", o_mem_w_data, 32'hDEADBEEF);
    @(negedge i_clk);
    i_pipe_w_en = 0;
    i_pipe_r_en = 1;
    #1;
    chk("pt_rdata", o_pipe_r_data, 32'hDEADBEEF);
    chk("pt_novalid", 32'(valid_cnt), 32'd0);
    i_pipe_r_en = 0;

    // full dump with latency check
    preload(0);
    i_pipe_halted = 1;
    base = rx.size();
    dbase = done_cnt;
    @(negedge i_clk) i_dump_start = 1'b1;
    @(posedge i_clk) #1 i_dump_start = 1'b0;
    chk("lat_busy", 32'(o_dump_busy), 32'd1);
    chk("lat_k0", 32'(o_tx_valid), 32'd0);
    @(posedge i_clk) #1;
    chk("lat_k1", 32'(o_tx_valid), 32'd0);
    @(posedge i_clk) #1;
    chk("lat_k2", 32'(o_tx_valid), 32'd1);
    chk("lat_byte0", 32'(o_tx_data), 32'd0);
    wait_idle("full_to");
    check_stream("full");
    for (int i = 0; i < 64; i += 21)
      chk("full_val", 32'(rx[base + i]), 32'(i));

    // backpressure
    ready_mode = 1;
    base = rx.size();
    dbase = done_cnt;
    pulse_start();
    wait_idle("bp_to");
    check_stream("bp");
    chk("bp_hold", 32'(viol), 32'd0);
    ready_mode = 0;

    // halt gating
    i_pipe_halted = 0;
    i_pipe_r_en = 1;
    i_pipe_addr = 6'h14;
    base = rx.size();
    dbase = done_cnt;
    pulse_start();
    repeat (5) @(posedge i_clk);
    #1;
    chk("hg_busy", 32'(o_dump_busy), 32'd1);
    chk("hg_valid", 32'(o_tx_valid), 32'd0);
    chk("hg_addr", 32'(o_mem_addr), 32'h14);
    chk("hg_ren", 32'(o_mem_r_en), 32'd1);
    i_pipe_halted = 1;
    wait_rx(21, "hg_w5_to");
    i_pipe_halted = 0;
    repeat (10) @(posedge i_clk);
    #1;
    chk("hg_w5_cnt", 32'(rx.size() - base), 32'd24);
    chk("hg_w6_valid", 32'(o_tx_valid), 32'd0);
    chk("hg_w6_addr", 32'(o_mem_addr), 32'h14);
    chk("hg_w6_busy", 32'(o_dump_busy), 32'd1);
    i_pipe_halted = 1;
    wait_idle("hg_to");
    check_stream("hg");
    i_pipe_r_en = 0;

    // random data, random ready, ignored second start
    preload(1);
    ready_mode = 2;
    base = rx.size();
    dbase = done_cnt;
    pulse_start();
    wait_rx(10, "ig_to");
    pulse_start();
    wait_idle("ig_idle_to");
    check_stream("ig");
    repeat (5) @(posedge i_clk);
    #1;
    chk("ig_norestart", 32'(o_dump_busy), 32'd0);
    ready_mode = 0;

    // async reset mid-dump
    preload(0);
    base = rx.size();
    dbase = done_cnt;
    pulse_start();
    wait_rx(13, "ar_to");
    #2 i_reset = 1'b1;
    #1;
    chk("ar_valid", 32'(o_tx_valid), 32'd0);
    chk("ar_busy", 32'(o_dump_busy), 32'd0);
    chk("ar_data", 32'(o_tx_data), 32'd0);
    @(negedge i_clk) i_reset = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    chk("ar_nodone", 32'(done_cnt - dbase), 32'd0);
    base = rx.size();
    dbase = done_cnt;
    pulse_start();
    wait_idle("ar2_to");
    check_stream("ar2");
    chk("viol", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
